path_delay_meter: RTL and testbench
===================================

PATH_DELAY_METER -- requirements
Module: path_delay_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the delay counters and outputs.
REQ-002 SHALL have parameter SETTLE_CYC, default 64, the number of idle cycles before each launch.
REQ-003 SHALL have parameter TIMEOUT, default 4095, the maximum count before abort; it SHALL be less than 2^CNT_W.
REQ-004 SHALL have parameter INVERTING, default 1; 1 means the path under test inverts its input.
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to begin a measurement; ignored unless in IDLE.
REQ-008 path_input  out  1  registered launch signal driven into the path under test.
REQ-009 path_result  in  1  asynchronous output of the path under test.
REQ-010 busy  out  1  high in every state except IDLE and DONE.
REQ-011 done  out  1  one-cycle pulse when a measurement ends (success or error).
REQ-012 rise_delay  out  CNT_W  delay for a 0->1 launch edge, held until the next done.
REQ-013 fall_delay  out  CNT_W  delay for a 1->0 launch edge, held until the next done.
REQ-014 err_timeout  out  1  the expected response did not arrive within TIMEOUT; held until the next start.
REQ-015 err_baseline  out  1  the path was not at its expected level after settling; held until the next start.

Function
REQ-016 path_result SHALL pass through a 2-flop synchronizer (sq1 -> sq2) before any use; the FSM SHALL observe only sq2.
REQ-017 The expected response to a launch level v SHALL be (v XOR INVERTING).
REQ-018 The FSM SHALL have the states IDLE, SETTLE0, RISE, SETTLE1, FALL and DONE.
REQ-019 IDLE: path_input=0; on start, clear both error flags, clear the counter, and go to SETTLE0.
REQ-020 SETTLE0: hold path_input=0 for SETTLE_CYC cycles, then check sq2 against the expected response to 0.
REQ-021 If that SETTLE0 check fails, set err_baseline and go to DONE; if it passes, set path_input=1 (the launch edge), clear the counter, and go to RISE.
REQ-022 RISE: on each edge, if sq2 equals the expected response to 1, latch rise_delay = counter+1 and go to SETTLE1; otherwise increment the counter.
REQ-023 Delay definition: the number of clock edges after the launch edge, up to and including the edge at which the match is observed; a zero-delay path SHALL report 3.
REQ-024 SETTLE1: hold path_input=1 for SETTLE_CYC cycles, then check the baseline against the expected response to 1 (as in REQ-020/021); on pass, set path_input=0, clear the counter, and go to FALL.
REQ-025 FALL: same rule as RISE, but matching the expected response to 0 and latching fall_delay; on match go to DONE.
REQ-026 In RISE or FALL, when the counter+1 reaches TIMEOUT without a match: set err_timeout, latch the affected delay output as TIMEOUT, and go to DONE.
REQ-027 DONE: assert done for exactly one cycle, force path_input=0, and return to IDLE.
REQ-028 start asserted while busy or in DONE SHALL be ignored and SHALL NOT restart the measurement.
REQ-029 A match and the timeout condition on the same edge SHALL resolve as a match.
REQ-030 The counter SHALL saturate and never wrap; delay outputs SHALL change only on a latch event.

Reset
REQ-031 On rst, asynchronously: state=IDLE, path_input=0, sq1=sq2=0, counter=0, rise_delay=0, fall_delay=0, busy=0, done=0, err_timeout=0, err_baseline=0.
REQ-032 rst asserted mid-measurement SHALL abort immediately with no done pulse; the first start after rst deasserts SHALL run a full measurement.

Verification
REQ-033 Inverting path model with 5-cycle rise and 7-cycle fall delay, default parameters, one start pulse -> rise_delay=8, fall_delay=10, one done pulse, both error flags 0.
REQ-034 Zero-delay inverting model -> rise_delay=3, fall_delay=3.
REQ-035 path_result stuck at 0, INVERTING=1 -> err_baseline=1 after SETTLE0, done pulse, path_input=0, rise_delay unchanged.
REQ-036 Path delay 5000 cycles, TIMEOUT=4095 -> err_timeout=1, rise_delay=4095, done pulse, no FALL phase.
REQ-037 start pulsed repeatedly during RISE, then rst asserted in SETTLE1 -> starts ignored, then all outputs at their reset values and no done pulse; a subsequent start completes a normal measurement.
REQ-038 Non-inverting model (INVERTING=0) with 4-cycle delays -> rise_delay=7, fall_delay=7, no errors.

Source files
------------

// File: rtl/path_delay_meter.sv
// -----------------------------------------------------------------------------
// path_delay_meter
//
// Measures the propagation delay of an external (asynchronous) path in clock
// cycles, for both a rising and a falling launch edge. One start request runs:
// settle low -> baseline check -> launch rising edge -> wait for response ->
// settle high -> baseline check -> launch falling edge -> wait for response.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous, active-high reset
//   start        in   one-cycle measurement request, honoured only in IDLE
//   path_input   out  registered launch signal into the path under test
//   path_result  in   asynchronous output of the path under test
//   busy         out  high while a measurement is running (not IDLE/DONE)
//   done         out  one-cycle pulse at the end of a measurement
//   rise_delay   out  delay for a 0->1 launch edge, held until the next done
//   fall_delay   out  delay for a 1->0 launch edge, held until the next done
//   err_timeout  out  response not seen within TIMEOUT, held until next start
//   err_baseline out  path not at its expected level after settling
// -----------------------------------------------------------------------------
module path_delay_meter #(
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 64,
  parameter int TIMEOUT    = 4095,
  parameter int INVERTING  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             path_input,
  input  logic             path_result,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rise_delay,
  output logic [CNT_W-1:0] fall_delay,
  output logic             err_timeout,
  output logic             err_baseline
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE0 = 3'd1,
    RISE    = 3'd2,
    SETTLE1 = 3'd3,
    FALL    = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Expected path response to a launch level v is v ^ INV_BIT.
  localparam logic             INV_BIT     = (INVERTING != 0);
  localparam logic             EXP_LOW     = INV_BIT;
  localparam logic             EXP_HIGH    = ~INV_BIT;
  localparam logic [CNT_W:0]   TIMEOUT_W   = (CNT_W+1)'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state, stateNext;
  logic             sq1, sq2;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [CNT_W-1:0] riseNext, fallNext;
  logic             pathInputNext, errToNext, errBlNext;
  logic [CNT_W:0]   cntPlus;

  // Saturating increment: the counter never wraps.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return v;
    return v + 1'b1;
  endfunction

  // One bit wider so counter+1 never overflows in the timeout compare.
  assign cntPlus = {1'b0, cnt} + 1'b1;

  // Two-flop synchronizer; only sq2 is ever observed by the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq1 <= 1'b0;
      sq2 <= 1'b0;
    end else begin
      sq1 <= path_result;
      sq2 <= sq1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      path_input   <= 1'b0;
      rise_delay   <= '0;
      fall_delay   <= '0;
      err_timeout  <= 1'b0;
      err_baseline <= 1'b0;
    end else begin
      state        <= stateNext;
      cnt          <= cntNext;
      path_input   <= pathInputNext;
      rise_delay   <= riseNext;
      fall_delay   <= fallNext;
      err_timeout  <= errToNext;
      err_baseline <= errBlNext;
    end
  end

  // Next-state and next-value logic
  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    pathInputNext = path_input;
    riseNext      = rise_delay;
    fallNext      = fall_delay;
    errToNext     = err_timeout;
    errBlNext     = err_baseline;

    case (state)
      IDLE: begin
        pathInputNext = 1'b0;
        if (start) begin
          errToNext = 1'b0;
          errBlNext = 1'b0;
          cntNext   = '0;
          stateNext = SETTLE0;
        end
      end

      SETTLE0: begin
        if (cnt == SETTLE_LAST) begin
          if (sq2 != EXP_LOW) begin
            errBlNext     = 1'b1;
            pathInputNext = 1'b0;
            stateNext     = DONE;
          end else begin
            pathInputNext = 1'b1;   // rising launch edge
            cntNext       = '0;
            stateNext     = RISE;
          end
        end else begin
          cntNext = satInc(cnt);
        end
      end

      RISE: begin
        // A match wins over a coincident timeout.
        if (sq2 == EXP_HIGH) begin
          riseNext  = cntPlus[CNT_W-1:0];
          cntNext   = '0;
          stateNext = SETTLE1;
        end else if (cntPlus >= TIMEOUT_W) begin
          errToNext     = 1'b1;
          riseNext      = TIMEOUT_C;
          pathInputNext = 1'b0;
          stateNext     = DONE;
        end else begin
          cntNext = satInc(cnt);
        end
      end

      SETTLE1: begin
        if (cnt == SETTLE_LAST) begin
          if (sq2 != EXP_HIGH) begin
            errBlNext     = 1'b1;
            pathInputNext = 1'b0;
            stateNext     = DONE;
          end else begin
            pathInputNext = 1'b0;   // falling launch edge
            cntNext       = '0;
            stateNext     = FALL;
          end
        end else begin
          cntNext = satInc(cnt);
        end
      end

      FALL: begin
        if (sq2 == EXP_LOW) begin
          fallNext  = cntPlus[CNT_W-1:0];
          stateNext = DONE;
        end else if (cntPlus >= TIMEOUT_W) begin
          errToNext = 1'b1;
          fallNext  = TIMEOUT_C;
          stateNext = DONE;
        end else begin
          cntNext = satInc(cnt);
        end
      end

      DONE: begin
        pathInputNext = 1'b0;
        stateNext     = IDLE;
      end

      default: begin
        pathInputNext = 1'b0;
        stateNext     = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_path_delay_meter.sv
// -----------------------------------------------------------------------------
// tb_path_delay_meter
//
// Two meters share clock and reset: u0 with default parameters (inverting
// path) and u1 non-inverting with short settle/timeout. Each drives its own
// behavioural path model whose output follows the launch level after a
// programmable number of clock edges (separately for rising and falling
// launches), or is stuck at a constant. Expected results come from the
// measurement rules: delay = path edges + 3 synchronizer/observe edges,
// clipped to TIMEOUT with an error when it would exceed it.
// -----------------------------------------------------------------------------
module tb_path_delay_meter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  start, pin, pres, busy, done, eto, ebl;
  logic [15:0] rise0, fall0;
  logic [7:0]  rise1, fall1;

  path_delay_meter #(.CNT_W(16), .SETTLE_CYC(64), .TIMEOUT(4095), .INVERTING(1)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .path_input(pin[0]),
    .path_result(pres[0]), .busy(busy[0]), .done(done[0]),
    .rise_delay(rise0), .fall_delay(fall0),
    .err_timeout(eto[0]), .err_baseline(ebl[0])
  );

  path_delay_meter #(.CNT_W(8), .SETTLE_CYC(16), .TIMEOUT(40), .INVERTING(0)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .path_input(pin[1]),
    .path_result(pres[1]), .busy(busy[1]), .done(done[1]),
    .rise_delay(rise1), .fall_delay(fall1),
    .err_timeout(eto[1]), .err_baseline(ebl[1])
  );

  int nTests = 0;
  int nFail  = 0;

  // Path model configuration, written by the stimulus
  int   dR[2];
  int   dF[2];
  int   mode[2];      // 0 = delayed follower, 1 = stuck
  logic stuckV[2];

  // Path model state and done pulse counters, owned by the model process
  logic lastIn[2];
  int   age[2];
  int   doneCnt[2];

  int prevRise[2];
  int prevFall[2];

  function automatic logic invOf(input int k);
    return (k == 0) ? 1'b1 : 1'b0;
  endfunction

  function automatic int timeoutOf(input int k);
    return (k == 0) ? 4095 : 40;
  endfunction

  function automatic int getRise(input int k);
    return (k == 0) ? int'(rise0) : int'(rise1);
  endfunction

  function automatic int getFall(input int k);
    return (k == 0) ? int'(fall0) : int'(fall1);
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Path model: output takes the new launch level (xor inversion) once
  // the configured number of clock edges has elapsed since the launch.
  initial begin
    for (int k = 0; k < 2; k++) begin
      lastIn[k]  = 1'b0;
      age[k]     = 1000000;
      doneCnt[k] = 0;
      pres[k]    = invOf(k);
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (done[k]) doneCnt[k]++;
        if (pin[k] !== lastIn[k]) begin
          lastIn[k] = pin[k];
          age[k]    = 0;
        end else if (age[k] < 1000000) begin
          age[k]++;
        end
        if (mode[k] != 0) pres[k] = stuckV[k];
        else if (age[k] >= (lastIn[k] ? dR[k] : dF[k])) pres[k] = lastIn[k] ^ invOf(k);
      end
    end
  end

  task automatic runMeas(input int k, input int dr, input int df, input int md, input logic sv);
    int t, eR, eF, eTo, eBl, d0, n, lim, w;
    string p;
    t   = timeoutOf(k);
    eR  = prevRise[k];
    eF  = prevFall[k];
    eTo = 0;
    eBl = 0;
    if (md != 0) begin
      if (sv != invOf(k)) eBl = 1;               // wrong level after low settle
      else begin eTo = 1; eR = t; end            // never responds to the rise
    end else if (dr + 3 > t) begin
      eTo = 1; eR = t;
    end else begin
      eR = dr + 3;
      if (df + 3 > t) begin eTo = 1; eF = t; end
      else eF = df + 3;
    end

    dR[k] = dr; dF[k] = df; mode[k] = md; stuckV[k] = sv;
    p  = $sformatf("u%0d[%0d/%0d/%0d]", k, dr, df, md);
    d0 = doneCnt[k];
    @(negedge clk); start[k] = 1'b1;
    @(negedge clk); start[k] = 1'b0;
    chk({p, ".busy"}, int'(busy[k]), 1);

    lim = 2 * t + 400;
    n   = 0;
    while (!done[k] && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({p, ".doneSeen"}, int'(done[k]), 1);
    chk({p, ".pinAtDone"}, int'(pin[k]), 0);
    @(negedge clk);
    chk({p, ".donePulse"}, int'(done[k]), 0);
    chk({p, ".busyAfter"}, int'(busy[k]), 0);
    chk({p, ".doneCount"}, doneCnt[k] - d0, 1);
    chk({p, ".rise"}, getRise(k), eR);
    chk({p, ".fall"}, getFall(k), eF);
    chk({p, ".errTimeout"}, int'(eto[k]), eTo);
    chk({p, ".errBaseline"}, int'(ebl[k]), eBl);
    prevRise[k] = eR;
    prevFall[k] = eF;

    // Let the path settle back to its idle level before the next run.
    w = 20;
    if (md == 0) w += (dr > df) ? dr : df;
    repeat (w) @(negedge clk);
    mode[k] = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int d0, n;
    rst = 1'b1;
    start = 2'b00;
    for (int k = 0; k < 2; k++) begin
      dR[k] = 0; dF[k] = 0; mode[k] = 0; stuckV[k] = 1'b0;
      prevRise[k] = 0; prevFall[k] = 0;
    end

    repeat (3) @(negedge clk);
    chk("reset.pin",   int'(pin[0]),  0);
    chk("reset.busy",  int'(busy[0]), 0);
    chk("reset.done",  int'(done[0]), 0);
    chk("reset.rise",  int'(rise0),   0);
    chk("reset.fall",  int'(fall0),   0);
    chk("reset.eto",   int'(eto[0]),  0);
    chk("reset.ebl",   int'(ebl[0]),  0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Directed cases on the default-parameter meter
    runMeas(0, 5, 7, 0, 1'b0);       // 8 / 10
    runMeas(0, 0, 0, 0, 1'b0);       // 3 / 3
    runMeas(0, 0, 0, 1, 1'b0);       // stuck low on inverting path: baseline error
    runMeas(0, 5000, 7, 0, 1'b0);    // rise timeout at 4095

    // Non-inverting meter: nominal, exact-TIMEOUT match, one past TIMEOUT
    runMeas(1, 4, 4, 0, 1'b0);
    runMeas(1, 37, 2, 0, 1'b0);
    runMeas(1, 38, 2, 0, 1'b0);
    runMeas(1, 3, 37, 0, 1'b0);
    runMeas(1, 3, 38, 0, 1'b0);

    // Randomized runs on the short-timeout meter
    for (int i = 0; i < 12; i++) begin
      int dr, df, md;
      logic sv;
      dr = $urandom_range(0, 45);
      df = $urandom_range(0, 45);
      md = ($urandom_range(0, 4) == 0) ? 1 : 0;
      sv = 1'($urandom_range(0, 1));
      runMeas(1, dr, df, md, sv);
    end

    // Starts during RISE are ignored; reset in SETTLE1 aborts silently.
    dR[0] = 5; dF[0] = 7; mode[0] = 0;
    d0 = doneCnt[0];
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    n = 0;
    while (pin[0] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort.launch", int'(pin[0]), 1);
    for (int i = 0; i < 3; i++) begin
      start[0] = 1'b1; @(negedge clk);
      start[0] = 1'b0; @(negedge clk);
    end
    chk("abort.ignoredStartPin", int'(pin[0]), 1);
    chk("abort.ignoredStartBusy", int'(busy[0]), 1);
    repeat (14) @(negedge clk);
    chk("abort.inSettle1", int'(pin[0]), 1);
    rst = 1'b1;
    #1;
    chk("abort.pin",  int'(pin[0]),  0);
    chk("abort.busy", int'(busy[0]), 0);
    chk("abort.done", int'(done[0]), 0);
    chk("abort.rise", int'(rise0),   0);
    chk("abort.fall", int'(fall0),   0);
    chk("abort.eto",  int'(eto[0]),  0);
    chk("abort.ebl",  int'(ebl[0]),  0);
    prevRise[0] = 0; prevFall[0] = 0;
    prevRise[1] = 0; prevFall[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort.noDone", doneCnt[0] - d0, 0);
    runMeas(0, 5, 7, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
